multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: FETCH_TIMEOUT, default 16, max cycles FETCH waits for imem_ready_i before faulting (legal range 1..255).
REQ-002 Parameter: CNT_W, default 32, width of retired-instruction counter.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-low reset.
REQ-006 run_i  input  1  level: 1 = execute instructions, 0 = stop at next instruction boundary.
REQ-007 imem_ready_i  input  1  instruction memory has valid data this cycle.
REQ-008 opcode_i  input  7  opcode field of the instruction register (IR output).
REQ-009 imem_req_o  output  1  fetch request to instruction memory.
REQ-010 ir_we_o  output  1  load IR from instruction memory.
REQ-011 pc_we_o  output  1  load PC with PC+4.
REQ-012 reg_we_o  output  1  register-file write enable.
REQ-013 alu_op_o  output  2  ALUOp to ALU control.
REQ-014 alu_src_o  output  1  0 = rs2 data, 1 = sign-extended immediate.
REQ-015 busy_o  output  1  1 in any state other than IDLE or HALT.
REQ-016 fault_o  output  2  sticky fault code: 00 none, 01 illegal opcode, 10 fetch timeout.
REQ-017 state_o  output  3  current state encoding, for debug.
REQ-018 retired_o  output  CNT_W  count of instructions completed through WB.

Function
REQ-019 States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Encodings 6 and 7 go to HALT with fault_o unchanged.
REQ-020 IDLE: if run_i=1, go to FETCH next cycle, else stay.
REQ-021 FETCH: imem_req_o=1 every cycle. If imem_ready_i=1, ir_we_o=1 in that same cycle and next state is DECODE; otherwise wait.
REQ-022 FETCH timeout: a wait counter clears on FETCH entry. The fault fires when the counter reaches FETCH_TIMEOUT cycles with imem_ready_i=0 → HALT, fault_o=10, no ir_we_o. If ready arrives in that same cycle, the fetch wins.
REQ-023 DECODE: one cycle. Register alu_op/alu_src from opcode_i.
  - 0110011 (R): alu_op=10, alu_src=0.
  - 0010011 (I): alu_op=11, alu_src=1.
  - Any other opcode: HALT with fault_o=01; no writes issued.
REQ-024 EXEC: exactly one cycle; alu_op_o/alu_src_o stay stable from DECODE exit through WB.
REQ-025 WB: one cycle with reg_we_o=1, pc_we_o=1, retired_o+1. Next state is FETCH if run_i=1, else IDLE.
REQ-026 Latency: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXEC, WB).
REQ-027 run_i deassert mid-instruction has no effect until WB completes.
REQ-028 Pulse widths: ir_we_o, reg_we_o and pc_we_o are each high at most one cycle per instruction and never high in the same cycle as each other except reg_we_o+pc_we_o in WB.
REQ-029 retired_o wraps modulo 2^CNT_W without fault.
REQ-030 HALT is absorbing: all enables 0, busy_o=0; only reset exits.
REQ-031 alu_op_o/alu_src_o hold their last decoded value in IDLE, FETCH and HALT.

Reset
REQ-032 Reset asserted, asynchronously: state=IDLE, all enables 0, alu_op_o=00, alu_src_o=0, fault_o=00, retired_o=0, wait counter=0.
REQ-033 Reset mid-WB: no further write pulse after reset assertion; the pending retire is not counted.
REQ-034 On reset release, the first state change occurs at the first rising edge with run_i=1.

Structure
REQ-035 Shared package holds:
  - state enum;
  - opcode constants OP_RTYPE/OP_ITYPE;
  - ALUOp constants;
  - fault code constants.
REQ-036 One sub-module, fetch_timer: wait counter plus timeout compare, cleared on FETCH entry.

Verification
REQ-037 run_i=1, imem_ready_i=1, opcode 0110011 → ir_we cycle 1, reg_we+pc_we cycle 4, alu_op=10, alu_src=0, retired_o=1.
REQ-038 opcode 0010011 with ready delayed 3 cycles → WB on cycle 7, alu_op=11, alu_src=1.
REQ-039 opcode 1111111 → HALT after DECODE, fault_o=01, no reg_we/pc_we, busy_o=0.
REQ-040 imem_ready_i held 0 for 16 cycles → HALT, fault_o=10; ready arriving on cycle 16 instead → normal DECODE.
REQ-041 run_i dropped during EXEC → WB completes, then IDLE, retired_o incremented once.
REQ-042 rst_i pulsed low during WB → all outputs at reset values immediately, retired_o=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle instruction-sequencing controller.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [1:0] ALU_OP_NONE = 2'b00;
  localparam logic [1:0] ALU_OP_R    = 2'b10;
  localparam logic [1:0] ALU_OP_I    = 2'b11;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle controller and its datapath/memory.
// Fetch handshake: a fetch completes in any cycle where imem_req_o and imem_ready_i are
// both high; imem_ready_i is ignored while imem_req_o is low.
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic             run_i;
  logic             imem_ready_i;
  logic [6:0]       opcode_i;
  logic             imem_req_o;
  logic             ir_we_o;
  logic             pc_we_o;
  logic             reg_we_o;
  logic [1:0]       alu_op_o;
  logic             alu_src_o;
  logic             busy_o;
  logic [1:0]       fault_o;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    output run_i, imem_ready_i, opcode_i,
    input  imem_req_o, ir_we_o, pc_we_o, reg_we_o, alu_op_o, alu_src_o,
           busy_o, fault_o, state_o, retired_o
  );

  modport slave (
    input  run_i, imem_ready_i, opcode_i,
    output imem_req_o, ir_we_o, pc_we_o, reg_we_o, alu_op_o, alu_src_o,
           busy_o, fault_o, state_o, retired_o
  );
endinterface

// File: rtl/multicycle_ctrl_fetch_timer.sv
// FETCH wait counter: held at zero outside FETCH, flags the last allowed wait cycle.
module multicycle_ctrl_fetch_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= 8'd0;
    end else if (!active) begin
      count <= 8'd0;
    end else if (count != LIMIT) begin
      count <= count + 8'd1;
    end
  end

  // count equals the number of FETCH cycles already spent, so LIMIT marks cycle TIMEOUT
  assign expired = active && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/WB sequencer with sticky fault reporting and retire counter.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  multicycle_ctrl_if.slave   bus
);

  state_t           state;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic [1:0]       fault;
  logic [CNT_W-1:0] retired;
  logic             fetch_expired;

  multicycle_ctrl_fetch_timer #(
    .TIMEOUT (FETCH_TIMEOUT)
  ) u_fetch_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .active  (state == S_FETCH),
    .expired (fetch_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= S_IDLE;
      alu_op  <= ALU_OP_NONE;
      alu_src <= 1'b0;
      fault   <= FAULT_NONE;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.run_i) state <= S_FETCH;
        end
        S_FETCH: begin
          // a ready arriving on the final wait cycle still completes the fetch
          if (bus.imem_ready_i) begin
            state <= S_DECODE;
          end else if (fetch_expired) begin
            state <= S_HALT;
            fault <= FAULT_TIMEOUT;
          end
        end
        S_DECODE: begin
          case (bus.opcode_i)
            OP_RTYPE: begin
              alu_op  <= ALU_OP_R;
              alu_src <= 1'b0;
              state   <= S_EXEC;
            end
            OP_ITYPE: begin
              alu_op  <= ALU_OP_I;
              alu_src <= 1'b1;
              state   <= S_EXEC;
            end
            default: begin
              state <= S_HALT;
              fault <= FAULT_ILLEGAL;
            end
          endcase
        end
        S_EXEC: begin
          state <= S_WB;
        end
        S_WB: begin
          retired <= retired + CNT_W'(1);
          state   <= bus.run_i ? S_FETCH : S_IDLE;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  assign bus.imem_req_o = (state == S_FETCH);
  assign bus.ir_we_o    = (state == S_FETCH) && bus.imem_ready_i;
  assign bus.reg_we_o   = (state == S_WB);
  assign bus.pc_we_o    = (state == S_WB);
  assign bus.busy_o     = (state != S_IDLE) && (state != S_HALT);
  assign bus.alu_op_o   = alu_op;
  assign bus.alu_src_o  = alu_src;
  assign bus.fault_o    = fault;
  assign bus.state_o    = state;
  assign bus.retired_o  = retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus corner-case sequences.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(
    .FETCH_TIMEOUT (16),
    .CNT_W         (32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        run;
    logic        ready;
    logic [6:0]  op;
    logic [2:0]  st;
    logic        req;
    logic        ir;
    logic        rw;
    logic        pw;
    logic [1:0]  aop;
    logic        src;
    logic        busy;
    logic [1:0]  flt;
    logic [31:0] ret;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(logic run, logic ready, logic [6:0] op, logic [2:0] st,
                              logic req, logic ir, logic rw, logic pw, logic [1:0] aop,
                              logic src, logic busy, logic [1:0] flt, logic [31:0] ret);
    vec_t v;
    v.run = run; v.ready = ready; v.op = op; v.st = st; v.req = req; v.ir = ir;
    v.rw = rw; v.pw = pw; v.aop = aop; v.src = src; v.busy = busy; v.flt = flt; v.ret = ret;
    return v;
  endfunction

  task automatic check_out(string name, logic [2:0] st, logic req, logic ir, logic rw,
                           logic pw, logic [1:0] aop, logic src, logic busy, logic [1:0] flt,
                           logic [31:0] ret);
    logic [12:0] act;
    logic [12:0] exp;
    act = {bus.state_o, bus.imem_req_o, bus.ir_we_o, bus.reg_we_o, bus.pc_we_o,
           bus.alu_op_o, bus.alu_src_o, bus.busy_o, bus.fault_o};
    exp = {st, req, ir, rw, pw, aop, src, busy, flt};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ctrl {st,req,ir,rw,pw,aop,src,busy,flt}: got %b want %b", name, act, exp);
    end
    checks++;
    if (bus.retired_o !== ret) begin
      failures++;
      $display("FAIL %s retired: got %0d want %0d", name, bus.retired_o, ret);
    end
  endtask

  task automatic drive(logic run, logic ready, logic [6:0] op);
    bus.run_i        = run;
    bus.imem_ready_i = ready;
    bus.opcode_i     = op;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, OP_R);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    //            run rdy op      st   req ir rw pw aop  src busy flt   ret
    tbl[0]  = mk(0, 0, OP_R,   3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    tbl[1]  = mk(0, 1, OP_R,   3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    tbl[2]  = mk(1, 0, OP_R,   3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    tbl[3]  = mk(1, 1, OP_R,   3'd1, 1, 1, 0, 0, 2'b00, 0, 1, 2'b00, 0);
    tbl[4]  = mk(1, 0, OP_R,   3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0);
    tbl[5]  = mk(1, 0, OP_BAD, 3'd3, 0, 0, 0, 0, 2'b10, 0, 1, 2'b00, 0);
    tbl[6]  = mk(1, 0, OP_BAD, 3'd4, 0, 0, 1, 1, 2'b10, 0, 1, 2'b00, 0);
    tbl[7]  = mk(1, 0, OP_I,   3'd1, 1, 0, 0, 0, 2'b10, 0, 1, 2'b00, 1);
    tbl[8]  = mk(1, 0, OP_I,   3'd1, 1, 0, 0, 0, 2'b10, 0, 1, 2'b00, 1);
    tbl[9]  = mk(1, 0, OP_I,   3'd1, 1, 0, 0, 0, 2'b10, 0, 1, 2'b00, 1);
    tbl[10] = mk(1, 1, OP_I,   3'd1, 1, 1, 0, 0, 2'b10, 0, 1, 2'b00, 1);
    tbl[11] = mk(1, 0, OP_I,   3'd2, 0, 0, 0, 0, 2'b10, 0, 1, 2'b00, 1);
    tbl[12] = mk(1, 1, OP_R,   3'd3, 0, 0, 0, 0, 2'b11, 1, 1, 2'b00, 1);
    tbl[13] = mk(1, 0, OP_R,   3'd4, 0, 0, 1, 1, 2'b11, 1, 1, 2'b00, 1);
    tbl[14] = mk(1, 1, OP_R,   3'd1, 1, 1, 0, 0, 2'b11, 1, 1, 2'b00, 2);
    tbl[15] = mk(1, 0, OP_R,   3'd2, 0, 0, 0, 0, 2'b11, 1, 1, 2'b00, 2);
    tbl[16] = mk(0, 0, OP_R,   3'd3, 0, 0, 0, 0, 2'b10, 0, 1, 2'b00, 2);
    tbl[17] = mk(0, 0, OP_R,   3'd4, 0, 0, 1, 1, 2'b10, 0, 1, 2'b00, 2);
    tbl[18] = mk(0, 1, OP_R,   3'd0, 0, 0, 0, 0, 2'b10, 0, 0, 2'b00, 3);

    // R-type zero-wait, I-type with 3 wait cycles, R-type with run dropped in EXEC
    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].run, tbl[i].ready, tbl[i].op);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].req, tbl[i].ir, tbl[i].rw,
                tbl[i].pw, tbl[i].aop, tbl[i].src, tbl[i].busy, tbl[i].flt, tbl[i].ret);
      next_cycle();
    end

    // illegal opcode: HALT after DECODE, absorbing even with run and ready high
    do_reset();
    drive(1'b1, 1'b1, OP_BAD);
    next_cycle();
    @(negedge clk);
    check_out("illegal_fetch", 3'd1, 1, 1, 0, 0, 2'b00, 0, 1, 2'b00, 0);
    next_cycle();
    @(negedge clk);
    check_out("illegal_decode", 3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      check_out($sformatf("illegal_halt%0d", k), 3'd5, 0, 0, 0, 0, 2'b00, 0, 0, 2'b01, 0);
    end

    // fetch timeout (ready never arrives) and the ready-on-last-cycle boundary
    for (int late = 0; late < 2; late++) begin
      do_reset();
      drive(1'b1, 1'b0, OP_I);
      next_cycle();
      for (int k = 1; k <= 16; k++) begin
        drive(1'b1, (late == 1) && (k == 16), OP_I);
        @(negedge clk);
        if (k == 15 || k == 16)
          check_out($sformatf("tmo%0d_cyc%0d", late, k), 3'd1, 1,
                    (late == 1) && (k == 16), 0, 0, 2'b00, 0, 1, 2'b00, 0);
        next_cycle();
      end
      drive(1'b1, 1'b0, OP_I);
      @(negedge clk);
      if (late == 0)
        check_out("tmo_halt", 3'd5, 0, 0, 0, 0, 2'b00, 0, 0, 2'b10, 0);
      else
        check_out("tmo_late_decode", 3'd2, 0, 0, 0, 0, 2'b00, 0, 1, 2'b00, 0);
      next_cycle();
    end

    // asynchronous reset in the middle of WB
    do_reset();
    drive(1'b1, 1'b1, OP_I);
    repeat (4) next_cycle();
    @(negedge clk);
    check_out("rst_pre_wb", 3'd4, 0, 0, 1, 1, 2'b11, 1, 1, 2'b00, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("rst_async", 3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    next_cycle();
    check_out("rst_held", 3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, OP_R);
    @(negedge clk);
    check_out("rst_release", 3'd0, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
